// File: rtl/bfxp_issue.sv
// Request front end for the bitfield extract/place unit: request FIFO, X hold stage, result handshake.
// Optional macro BFXP_ISSUE_BYPASS_EN lets a request skip the empty FIFO straight into X.
module bfxp_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_rs1,
  input  logic [14:0]      req_ctrl,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      ex_rs1,
  output logic [4:0]       ex_start,
  output logic [4:0]       ex_len,
  output logic [4:0]       ex_dest,
  input  logic [31:0]      ex_rd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      rs1;
    logic [4:0]       start;
    logic [4:0]       len;
    logic [4:0]       dest;
    logic             err;
    logic [TAG_W-1:0] tag;
  } op_t;

  // 6-bit sums so a field running past bit 31 is visible as a value above 32.
  function automatic logic range_err(input logic [4:0] start, input logic [4:0] len,
                                     input logic [4:0] dest);
    logic [5:0] s_end;
    logic [5:0] d_end;
    s_end = {1'b0, start} + {1'b0, len};
    d_end = {1'b0, dest} + {1'b0, len};
    return (s_end > 6'd32) || (d_end > 6'd32);
  endfunction

  op_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  op_t         x_q, x_d;
  logic        x_valid_q, x_valid_d;
  logic        x_settled_q, x_settled_d;

  op_t  req_op;
  logic push_acc;
  logic fifo_wr;
  logic fifo_empty;
  logic retire;
  logic x_free;
  logic pop;
  logic byp;

  always_comb begin
    req_op       = '0;
    req_op.rs1   = req_rs1;
    req_op.start = req_ctrl[4:0];
    req_op.len   = req_ctrl[9:5];
    req_op.dest  = req_ctrl[14:10];
    req_op.err   = range_err(req_ctrl[4:0], req_ctrl[9:5], req_ctrl[14:10]);
    req_op.tag   = req_tag;
  end

  // req_ready looks only at the registered count, never at res_ready.
  assign req_ready  = !reset && (count_q < FULL);
  assign push_acc   = req_valid && req_ready;
  assign fifo_empty = (count_q == '0);
  assign res_valid  = x_valid_q && x_settled_q;
  assign retire     = res_valid && res_ready;
  assign x_free     = !x_valid_q || retire;
  assign pop        = x_free && !fifo_empty;

`ifdef BFXP_ISSUE_BYPASS_EN
  assign byp = push_acc && fifo_empty && x_free;
`else
  assign byp = 1'b0;
`endif

  assign fifo_wr = push_acc && !byp;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
    x_settled_d = x_settled_q;

    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (fifo_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    // X holds its op frozen until retire so the extractor keeps recomputing the same result.
    if (pop) begin
      x_d         = mem_q[rd_ptr_q];
      x_valid_d   = 1'b1;
      x_settled_d = 1'b0;
    end else if (byp) begin
      x_d         = req_op;
      x_valid_d   = 1'b1;
      x_settled_d = 1'b0;
    end else if (retire) begin
      x_valid_d   = 1'b0;
      x_settled_d = 1'b0;
    end else if (x_valid_q && !x_settled_q) begin
      x_settled_d = 1'b1;
    end
  end

  // FIFO storage: data only, contents are don't-care while count says empty.
  always_ff @(posedge clock) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= req_op;
  end

  // Control and X stage registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      x_settled_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      x_settled_q <= x_settled_d;
    end
  end

  assign ex_rs1   = x_q.rs1;
  assign ex_start = x_q.start;
  assign ex_len   = x_q.len;
  assign ex_dest  = x_q.dest;
  assign res_data = ex_rd;
  assign res_tag  = x_q.tag;
  assign res_err  = x_q.err;

endmodule

// File: tb/tb_bfxp_issue.sv
// Bench for bfxp_issue: stub registered extractor, queue-based reference model, directed + random traffic.
module tb_bfxp_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef BFXP_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_rs1 = '0;
  logic [14:0]      req_ctrl = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      ex_rs1;
  logic [4:0]       ex_start, ex_len, ex_dest;
  logic [31:0]      ex_rd = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  always #5 clock = ~clock;

  bfxp_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .ex_rs1(ex_rs1), .ex_start(ex_start), .ex_len(ex_len), .ex_dest(ex_dest),
    .ex_rd(ex_rd),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_err(res_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stub extractor: bit-by-bit placement, registered on the clock.
  function automatic logic [31:0] stub_x(input logic [31:0] rs1, input logic [4:0] s,
                                         input logic [4:0] l, input logic [4:0] d);
    logic [31:0] o;
    int si, li, di;
    si = int'(s); li = int'(l); di = int'(d);
    o = '0;
    if (si + li > 32 || di + li > 32) return '0;
    for (int i = 0; i < 32; i++)
      if (i >= di && i < di + li) o[i] = rs1[i - di + si];
    return o;
  endfunction

  always @(posedge clock) ex_rd <= stub_x(ex_rs1, ex_start, ex_len, ex_dest);

  typedef struct packed {
    logic [31:0]      rs1;
    logic [14:0]      ctrl;
    logic [TAG_W-1:0] tag;
  } op_t;

  function automatic logic ref_err(input op_t o);
    int s, l, d;
    s = int'(o.ctrl[4:0]); l = int'(o.ctrl[9:5]); d = int'(o.ctrl[14:10]);
    return (s + l > 32) || (d + l > 32);
  endfunction

  function automatic logic [31:0] ref_data(input op_t o);
    longint unsigned f;
    int s, l, d;
    s = int'(o.ctrl[4:0]); l = int'(o.ctrl[9:5]); d = int'(o.ctrl[14:10]);
    if (ref_err(o)) return '0;
    f = ({32'd0, o.rs1} >> s) & ((64'd1 << l) - 64'd1);
    return 32'(f << d);
  endfunction

  function automatic logic [14:0] mk_ctrl(input int s, input int l, input int d);
    return {5'(d), 5'(l), 5'(s)};
  endfunction

  op_t exp_q[$];
  int  retired = 0;
  bit  rand_rdy = 1'b0;

  // Monitor: every accept enters the model queue, every retire is compared against its head.
  initial begin
    op_t e;
    op_t pe;
    int  n;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
      end else begin
        n = exp_q.size();
        if (res_valid && res_ready) begin
          if (n == 0) chk("stale_result", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("res_tag", 32'(res_tag), 32'(e.tag));
            chk("res_data", res_data, ref_data(e));
            chk("res_err", 32'(res_err), 32'(ref_err(e)));
            retired++;
          end
        end
        if (req_valid && req_ready) begin
          chk("push_bound", 32'(n <= DEPTH), 32'd1);
          pe.rs1 = req_rs1; pe.ctrl = req_ctrl; pe.tag = req_tag;
          exp_q.push_back(pe);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] rs1, input logic [14:0] ctrl, input logic [TAG_W-1:0] tag);
    req_rs1 = rs1; req_ctrl = ctrl; req_tag = tag; req_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (req_ready) begin
        @(posedge clock); #1;
        req_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_res();
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (res_valid) return;
    end
    chk("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !res_valid) begin
        @(posedge clock); #1;
        return;
      end
    end
    chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0]      r, held_d;
    logic [TAG_W-1:0] held_t;
    int               cnt, base;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_ex_rs1", ex_rs1, 32'd0);
    chk("post_rst_ex_fields", 32'({ex_start, ex_len, ex_dest}), 32'd0);
    chk("post_rst_tag_err", 32'({res_tag, res_err}), 32'd0);
    @(posedge clock); #1;

    // Basic extract with latency
    send(32'hDEADBEEF, mk_ctrl(8, 8, 0), 4'd3);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      chk("lat_low", 32'(res_valid), 32'd0);
    end
    @(negedge clock);
    chk("lat_high", 32'(res_valid), 32'd1);
    chk("basic_data", res_data, 32'h000000BE);
    chk("basic_tag", 32'(res_tag), 32'd3);
    chk("basic_err", 32'(res_err), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("basic_single", 32'(res_valid), 32'd0);
    @(posedge clock); #1;

    // Out of range on source side, then on destination side
    send($urandom, mk_ctrl(20, 16, 0), 4'd5);
    wait_res();
    chk("oor_src_err", 32'(res_err), 32'd1);
    chk("oor_src_data", res_data, 32'd0);
    @(posedge clock); #1;
    send($urandom, mk_ctrl(0, 16, 20), 4'd6);
    wait_res();
    chk("oor_dst_err", 32'(res_err), 32'd1);
    chk("oor_dst_data", res_data, 32'd0);
    @(posedge clock); #1;

    // dest+len exactly 32
    r = $urandom;
    send(r, mk_ctrl(0, 31, 1), 4'd9);
    wait_res();
    chk("bound_err", 32'(res_err), 32'd0);
    chk("bound_data", res_data, (r << 1) & 32'hFFFFFFFE);
    @(posedge clock); #1;

    // Backpressure: hold a result, fill the FIFO, then drain
    res_ready = 1'b0;
    send($urandom, mk_ctrl(4, 12, 8), 4'd1);
    wait_res();
    held_d = res_data; held_t = res_tag;
    @(posedge clock); #1;
    cnt = 0;
    req_rs1 = $urandom; req_ctrl = 15'($urandom); req_tag = 4'd2; req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bit acc;
      @(negedge clock);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, held_d);
      chk("hold_tag", 32'(res_tag), 32'(held_t));
      acc = req_ready;
      @(posedge clock); #1;
      if (acc) begin
        cnt++;
        req_rs1 = $urandom; req_ctrl = 15'($urandom); req_tag = TAG_W'(cnt + 2);
      end
    end
    req_valid = 1'b0;
    chk("fill_count", 32'(cnt), 32'(DEPTH));
    chk("full_ready", 32'(req_ready), 32'd0);
    base = retired;
    res_ready = 1'b1;
    wait_drain();
    chk("drain_count", 32'(retired - base), 32'(DEPTH + 1));

    // Stream 3*DEPTH tagged requests through random backpressure
    base = retired;
    rand_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) send($urandom, 15'($urandom), TAG_W'(i));
    rand_rdy = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    chk("wrap_count", 32'(retired - base), 32'(3 * DEPTH));

    // Random gaps, random control words, random ready
    base = retired;
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      send($urandom, mk_ctrl($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)),
           TAG_W'($urandom));
    end
    rand_rdy = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    chk("rand_count", 32'(retired - base), 32'd30);

    // Reset with one op in X and three queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, mk_ctrl(0, 8, 0), TAG_W'(10 + i));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rst_no_stale", 32'(res_valid), 32'd0);
    end
    @(posedge clock); #1;
    r = $urandom;
    send(r, mk_ctrl(16, 16, 0), 4'd7);
    wait_res();
    chk("post_rst_new_tag", 32'(res_tag), 32'd7);
    chk("post_rst_new_data", res_data, {16'd0, r[31:16]});
    @(posedge clock); #1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
